// File: rtl/fdt_act_pkg.sv
// Shared types and helpers for the FDT activation arbiter: FSM states,
// lane geometry and the negative-lane counter used by the statistics path.
package fdt_act_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_LOCK = 1'b1
   } state_t;

   localparam int LANES  = 8;
   localparam int ZCNT_W = 32;

   // Number of set sign bits in one beat, i.e. lanes that ReLU clamps to zero.
   function automatic logic [3:0] lane_count(input logic [LANES-1:0] signs);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < LANES; i++) begin
         n = n + {3'b000, signs[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/fdt_act_rr_pick.sv
// Combinational round-robin pick: first requester with valid set, searching
// upward from the pointer with wrap-around.
module fdt_act_rr_pick #(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_rr,
   output logic [IDW-1:0]  o_grant,
   output logic            o_any
);

   always_comb begin
      int idx;
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      o_grant = '0;
      o_any   = 1'b0;
      idx     = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(i_rr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!o_any && i_req[idx]) begin
            o_any   = 1'b1;
            o_grant = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/fdt_act_arb.sv
// Burst-granular round-robin share of one 8-lane ReLU stage with a registered
// valid/ready output. Define FDT_ACT_STAT_EN to enable the clamped-lane counter.
module fdt_act_arb
   import fdt_act_pkg::*;
#(
   parameter int DW   = 8,
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NREQ-1:0]                    req_vld,
   output logic [NREQ-1:0]                    req_rdy,
   input  logic [NREQ-1:0][LANES-1:0][DW-1:0] req_data,
   input  logic [NREQ-1:0]                    req_last,
   output logic                               out_vld,
   input  logic                               out_rdy,
   output logic [LANES-1:0][DW-1:0]           out_data,
   output logic                               out_last,
   output logic [IDW-1:0]                     out_id,
   input  logic                               stat_clr,
   output logic [ZCNT_W-1:0]                  zero_cnt
);

   state_t                   r_state;
   logic [IDW-1:0]           r_own;
   logic [IDW-1:0]           r_rr;
   logic                     r_out_vld;
   logic [LANES-1:0][DW-1:0] r_out_data;
   logic                     r_out_last;
   logic [IDW-1:0]           r_out_id;

   logic [IDW-1:0]           w_pick;
   logic                     w_any;
   logic [IDW-1:0]           w_gnt;
   logic                     w_gnt_vld;
   logic                     w_pr;
   logic                     w_acc;
   logic                     w_last;
   logic [LANES-1:0][DW-1:0] w_sel;
   logic [LANES-1:0][DW-1:0] w_relu;

   fdt_act_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .i_req   (req_vld),
      .i_rr    (r_rr),
      .o_grant (w_pick),
      .o_any   (w_any)
   );

   // The output stage can take a beat whenever it is empty or draining this cycle.
   assign w_pr      = !r_out_vld || out_rdy;
   assign w_gnt     = (r_state == S_LOCK) ? r_own : w_pick;
   assign w_gnt_vld = (r_state == S_LOCK) ? req_vld[r_own] : w_any;
   assign w_acc     = w_gnt_vld && w_pr;
   assign w_sel     = req_data[w_gnt];
   assign w_last    = req_last[w_gnt];

   always_comb begin
      req_rdy = '0;
      if (r_state == S_LOCK || w_any) req_rdy[w_gnt] = w_pr;
   end

   always_comb begin
      w_relu = '0;
      for (int l = 0; l < LANES; l++) begin
         w_relu[l] = w_sel[l][DW-1] ? '0 : w_sel[l];
      end
   end

   function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
      return (idx == IDW'(NREQ - 1)) ? '0 : idx + IDW'(1);
   endfunction

   // IDLE arbitrates every cycle; LOCK pins the grant until the owner's last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_own   <= '0;
         r_rr    <= '0;
      end else if (w_acc) begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
         case (r_state)
            S_IDLE: begin
               if (w_last) begin
                  r_rr <= next_idx(w_gnt);
               end else begin
                  r_state <= S_LOCK;
                  r_own   <= w_gnt;
               end
            end
            S_LOCK: begin
               if (w_last) begin
                  r_state <= S_IDLE;
                  r_rr    <= next_idx(r_own);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the data register is reset as well because its idle value is observable on out_data.
         r_out_vld  <= 1'b0;
         r_out_data <= '0;
         r_out_last <= 1'b0;
         r_out_id   <= '0;
      end else if (w_acc) begin
         r_out_vld  <= 1'b1;
         r_out_data <= w_relu;
         r_out_last <= w_last;
         r_out_id   <= w_gnt;
      end else if (out_rdy) begin
         r_out_vld  <= 1'b0;
      end
   end

   assign out_vld  = r_out_vld;
   assign out_data = r_out_data;
   assign out_last = r_out_last;
   assign out_id   = r_out_id;

`ifdef FDT_ACT_STAT_EN
   logic [LANES-1:0]  w_sign;
   logic [3:0]        w_neg;
   logic [ZCNT_W:0]   w_sum;
   logic [ZCNT_W-1:0] r_zero_cnt;

   always_comb begin
      w_sign = '0;
      for (int l = 0; l < LANES; l++) begin
         w_sign[l] = w_sel[l][DW-1];
      end
   end

   assign w_neg = lane_count(w_sign);
   assign w_sum = {1'b0, r_zero_cnt} + (ZCNT_W + 1)'(w_neg);

   // A clear that coincides with an accepted beat restarts from that beat's count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_zero_cnt <= '0;
      end else if (stat_clr) begin
         r_zero_cnt <= w_acc ? ZCNT_W'(w_neg) : '0;
      end else if (w_acc) begin
         r_zero_cnt <= w_sum[ZCNT_W] ? '1 : w_sum[ZCNT_W-1:0];
      end
   end

   assign zero_cnt = r_zero_cnt;
`else
   logic w_unused_stat;
   assign w_unused_stat = stat_clr;
   assign zero_cnt      = '0;
`endif

endmodule

// File: doc/fdt_act_arb.md
# fdt_act_arb

Round-robin scheduler that shares one 8-lane signed ReLU activation stage between NREQ requester streams in the FDT datapath (e.g. conv engine, FC engine). It grants the stage burst by burst, applies ReLU to each accepted 8-lane beat, and presents results on one registered valid/ready output tagged with the owner ID. An optional statistics counter records how many lanes were clamped to zero.

## Interface
- DW, 8: signed lane width
- NREQ, 2: number of requesters (2..4)
- IDW, $clog2(NREQ): ID width (derived)
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- req_vld  in  NREQ  per-requester beat valid
- req_rdy  out  NREQ  per-requester beat accepted
- req_data  in  NREQ×8×DW  per-requester 8-lane signed beat
- req_last  in  NREQ  final beat of requester's burst
- out_vld  out  1  result valid
- out_rdy  in  1  downstream ready
- out_data  out  8×DW  ReLU result
- out_last  out  1  last beat of granted burst
- out_id  out  IDW  owner of the beat
- stat_clr  in  1  synchronous clear of zero_cnt
- zero_cnt  out  32  clamped-lane count (see Configuration)

## Operation
- ReLU per lane: lane MSB 1 (negative, signed DW) -> 0; otherwise pass unchanged. Zero passes as zero; most-negative value -> 0.
- Pipe-ready: pr = !out_vld || out_rdy. A beat is accepted when the granted req_vld & pr; req_rdy[g] = pr for the granted g only, 0 for all others.
- FSM IDLE / LOCK, plus owner register own and round-robin pointer rr (both reset 0).
- IDLE: grant g = first requester with req_vld set, searching from rr upward with wrap. Accept same cycle if pr. Accepted beat with req_last=1 -> stay IDLE, rr = g+1 (mod NREQ). Accepted beat with req_last=0 -> LOCK, own = g. No valid or !pr -> stay IDLE, rr unchanged.
- LOCK: grant fixed to own; other requesters stalled regardless of valid. Accepted beat with req_last=1 -> IDLE, rr = own+1 (mod NREQ).
- Output register loads {relu(data), last, id} on acceptance; out_vld clears when out_rdy and no new acceptance.
- Simultaneous out_rdy and new acceptance: register reloads, out_vld stays 1 (no bubble).
- Requester dropping req_vld mid-burst: LOCK holds; no other requester is served until owner delivers req_last.
- Reset mid-burst: FSM -> IDLE, rr = 0, out_vld = 0; the partial burst is discarded.

## Timing
- Reset values: out_vld 0, out_data 0, out_last 0, out_id 0, req_rdy 0 (combinational from out_vld=0 gives pr=1 but no grant without valid), zero_cnt 0.
- Latency: 1 cycle from acceptance to out_vld.
- Throughput: 1 beat/cycle while out_rdy held high, including across burst boundaries (IDLE arbitration is same-cycle).
- req_rdy combinationally depends on req_vld (in IDLE) and out_rdy; requesters must not gate req_vld on req_rdy.
- No combinational path from req_data to out_data.

## Configuration
- FDT_ACT_STAT_EN defined: zero_cnt adds the number of negative lanes (0..8) of every accepted beat, saturates at 2^32-1, and clears on stat_clr. stat_clr coincident with an accepted beat: the counter loads that beat's count.
- Not defined: zero_cnt tied to 0, stat_clr ignored, no counter logic; ports kept for a stable interface.

## Structure
- fdt_act_pkg: state enum {IDLE, LOCK}, LANES=8, ZCNT_W=32, lane-count function (popcount of lane sign bits).
- Sub-module fdt_act_rr_pick: combinational round-robin pick (req vector, rr pointer -> grant index, any-valid).
- ReLU lanes and output register inline in fdt_act_arb.

## Test plan
- Single requester 0, 3-beat burst, lanes {-1,5,-128,127,0,-2,3,-7}, out_rdy=1 -> out_data {0,5,0,127,0,0,3,0} one cycle after each beat, out_last on beat 3, out_id=0.
- Both requesters valid continuously, 2-beat bursts each -> outputs alternate bursts 0,1,0,1; no interleaving inside a burst; no idle cycles.
- Owner 1 drops req_vld for 4 cycles mid-burst while requester 0 valid -> req_rdy[0] stays 0 until requester 1's last beat is accepted, then requester 0 is granted.
- out_rdy low for 3 cycles with a beat held in the output register -> out_data stable, req_rdy all 0, no beat lost or duplicated after out_rdy returns.
- rst_n asserted in LOCK after 2 of 4 beats -> out_vld 0 immediately, next grant uses rr=0.
- FDT_ACT_STAT_EN: 10 beats each with 3 negative lanes -> zero_cnt=30; stat_clr with a beat of 2 negatives -> zero_cnt=2; without the macro zero_cnt stays 0.
